// File: rtl/mult_bist_pkg.sv
// Shared definitions for the Booth multiplier BIST path: ORA state encoding and
// default MISR/product geometry also used by the pattern generator.
package mult_bist_pkg;

    localparam int          DEF_PROD_W = 8;
    localparam int          DEF_SIG_W  = 16;
    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_SEED   = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } ora_state_t;

endpackage

// File: rtl/mult_misr.sv
// Multiple-input signature register: Galois-style shift with polynomial feedback,
// product XORed into the low bits on every enabled cycle.
module mult_misr
    import mult_bist_pkg::*;
#(
    parameter int               PROD_W  = DEF_PROD_W,
    parameter int               SIG_W   = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] RST_VAL = SIG_W'(DEF_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [SIG_W-1:0]  seed,
    input  logic [PROD_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] feedback;
    logic [SIG_W-1:0] sig_next;

    always_comb begin
        feedback = sig[SIG_W-1] ? POLY : '0;
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ SIG_W'(din);
    end

    // Load takes priority so a new session always starts from a clean seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= RST_VAL;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/mult_ora.sv
// Output response analyser for the Booth multiplier BIST: issues one start per
// vector, captures each product into the MISR and compares against a golden value.
module mult_ora
    import mult_bist_pkg::*;
#(
    parameter int               PROD_W    = DEF_PROD_W,
    parameter int               SIG_W     = DEF_SIG_W,
    parameter int               N_VECTORS = 64,
    parameter logic [SIG_W-1:0] POLY      = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED      = SIG_W'(DEF_SEED),
    parameter logic [SIG_W-1:0] GOLDEN    = '0,
    parameter int               TIMEOUT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_en,
    input  logic              busy,
    input  logic [PROD_W-1:0] prod,
    output logic              start,
    output logic [SIG_W-1:0]  signature,
    output logic [15:0]       vec_count,
    output logic              done,
    output logic              pass,
    output logic              timeout
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    ora_state_t       state;
    ora_state_t       state_next;
    logic [WC_W-1:0]  wait_cnt;
    logic [15:0]      vec_count_r;
    logic             timeout_r;
    logic             session_start;
    logic             capture;
    logic             timed_out;
    logic             last_vec;

    assign last_vec = (vec_count_r + 16'd1) == 16'(N_VECTORS);

    // Abort has priority over capture and timeout; busy is stale while wait_cnt is 0.
    always_comb begin
        state_next    = state;
        start         = 1'b0;
        done          = 1'b0;
        session_start = 1'b0;
        capture       = 1'b0;
        timed_out     = 1'b0;
        case (state)
            IDLE: begin
                if (test_en) begin
                    session_start = 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                start      = 1'b1;
                state_next = test_en ? WAIT : IDLE;
            end
            WAIT: begin
                if (!test_en) begin
                    state_next = IDLE;
                end else if ((wait_cnt != '0) && !busy) begin
                    capture    = 1'b1;
                    state_next = last_vec ? DONE : ISSUE;
                end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!test_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            vec_count_r <= '0;
            timeout_r   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + WC_W'(1);
            end
            if (session_start) begin
                vec_count_r <= '0;
                timeout_r   <= 1'b0;
            end else if (capture) begin
                vec_count_r <= vec_count_r + 16'd1;
            end
            if (timed_out) begin
                timeout_r <= 1'b1;
            end
        end
    end

    mult_misr #(
        .PROD_W  (PROD_W),
        .SIG_W   (SIG_W),
        .POLY    (POLY),
        .RST_VAL (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (session_start),
        .en   (capture),
        .seed (SEED),
        .din  (prod),
        .sig  (signature)
    );

    assign vec_count = vec_count_r;
    assign timeout   = timeout_r;
    assign pass      = done && (signature == GOLDEN) && !timeout_r;

endmodule

// File: tb/tb_mult_ora.sv
// Bench for mult_ora: three instances (single vector, two-vector aliasing table,
// 64-vector LFSR session) each driven by a behavioural multiplier with 4-cycle busy.
module tb_mult_ora;

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [15:0] s1;
        logic [15:0] s2;
        logic        exp_pass;
    } vec_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] lfsr_prod(input int k);
        logic [7:0] l;
        l = 8'hA5;
        for (int i = 0; i < k; i++) l = lfsr_step(l);
        return {4'h0, l[7:4]} * {4'h0, l[3:0]};
    endfunction

    // Reference signature after n vectors of the LFSR pattern, seed FFFF.
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] s;
        logic [7:0]  l;
        logic [7:0]  p;
        s = 16'hFFFF;
        l = 8'hA5;
        for (int i = 0; i < n; i++) begin
            p = {4'h0, l[7:4]} * {4'h0, l[3:0]};
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, p};
            l = lfsr_step(l);
        end
        return s;
    endfunction

    localparam logic [15:0] GOLD64 = model_sig(64);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  te;
    logic [2:0]  hang;
    logic [2:0]  start;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  pass;
    logic [2:0]  tmo;
    logic [7:0]  prod [3];
    logic [15:0] sig [3];
    logic [15:0] vec [3];
    logic [7:0]  prod_tab [2];
    logic        mon_en;
    int          tests = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mult_ora #(.N_VECTORS(1), .GOLDEN(16'hEFD9)) u_dut0 (
        .clk(clk), .rst(rst), .test_en(te[0]), .busy(busy[0]), .prod(prod[0]),
        .start(start[0]), .signature(sig[0]), .vec_count(vec[0]), .done(done[0]),
        .pass(pass[0]), .timeout(tmo[0])
    );

    mult_ora #(.N_VECTORS(2), .SEED(16'h0000), .GOLDEN(16'h0000)) u_dut1 (
        .clk(clk), .rst(rst), .test_en(te[1]), .busy(busy[1]), .prod(prod[1]),
        .start(start[1]), .signature(sig[1]), .vec_count(vec[1]), .done(done[1]),
        .pass(pass[1]), .timeout(tmo[1])
    );

    mult_ora #(.N_VECTORS(64), .GOLDEN(GOLD64)) u_dut2 (
        .clk(clk), .rst(rst), .test_en(te[2]), .busy(busy[2]), .prod(prod[2]),
        .start(start[2]), .signature(sig[2]), .vec_count(vec[2]), .done(done[2]),
        .pass(pass[2]), .timeout(tmo[2])
    );

    function automatic logic [7:0] pattern(input int g, input int k);
        logic [7:0] mc;
        logic [7:0] mp;
        mc = 8'd2;
        mp = 8'd3;
        if (g == 0) return mc * mp;
        if (g == 1) return (k == 0) ? prod_tab[0] : prod_tab[1];
        return lfsr_prod(k);
    endfunction

    // Behavioural multipliers: busy high for 4 cycles after sampling start (or forever when hung).
    logic [2:0] rem [3];
    int         idx [3];
    logic [2:0] hung;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 3; g++) begin
                rem[g]  <= 3'd0;
                idx[g]  <= 0;
                hung[g] <= 1'b0;
                prod[g] <= 8'h00;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (start[g]) begin
                    rem[g]  <= 3'd4;
                    prod[g] <= pattern(g, idx[g]);
                    hung[g] <= hang[g];
                end else if (rem[g] != 3'd0) begin
                    rem[g] <= rem[g] - 3'd1;
                end
                if (!te[g]) begin
                    idx[g]  <= 0;
                    hung[g] <= 1'b0;
                end else if (start[g]) begin
                    idx[g] <= idx[g] + 1;
                end
            end
        end
    end

    assign busy[0] = (rem[0] != 3'd0) || hung[0];
    assign busy[1] = (rem[1] != 3'd0) || hung[1];
    assign busy[2] = (rem[2] != 3'd0) || hung[2];

    // Start-pulse monitor for the 64-vector instance.
    int cyc = 0;
    int start_cnt = 0;
    int spacing_bad = 0;
    int last_start = -1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mon_en) begin
            start_cnt   <= 0;
            spacing_bad <= 0;
            last_start  <= -1;
        end else if (start[2]) begin
            start_cnt <= start_cnt + 1;
            if (last_start >= 0 && (cyc - last_start) != 6) spacing_bad <= spacing_bad + 1;
            last_start <= cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int g, input logic en);
        @(negedge clk);
        te[g] = en;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t tbl [4];
    int   n;
    logic done_seen;

    initial begin
        te = 3'b000;
        hang = 3'b000;
        mon_en = 1'b0;
        prod_tab[0] = 8'h00;
        prod_tab[1] = 8'h00;
        #1 rst = 1'b1;
        tick(2);
        checkOutput("reset start", 32'(start), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset pass", 32'(pass), 32'h0);
        checkOutput("reset timeout", 32'(tmo), 32'h0);
        checkOutput("reset vec_count", 32'(vec[2]), 32'h0);
        checkOutput("reset sig dut0", 32'(sig[0]), 32'hFFFF);
        checkOutput("reset sig dut1", 32'(sig[1]), 32'h0000);
        @(negedge clk) rst = 1'b0;

        // Single vector 2*3 from seed FFFF.
        applyStimulus(0, 1'b1);
        tick(1);
        checkOutput("single start pulse", 32'(start[0]), 32'h1);
        tick(1);
        checkOutput("single start drops", 32'(start[0]), 32'h0);
        tick(4);
        checkOutput("single done early", 32'(done[0]), 32'h0);
        tick(1);
        checkOutput("single done", 32'(done[0]), 32'h1);
        checkOutput("single signature", 32'(sig[0]), 32'hEFD9);
        checkOutput("single pass", 32'(pass[0]), 32'h1);
        checkOutput("single vec_count", 32'(vec[0]), 32'h1);
        checkOutput("single timeout", 32'(tmo[0]), 32'h0);
        applyStimulus(0, 1'b0);
        tick(1);
        checkOutput("single back to idle", 32'(done[0]), 32'h0);

        // Two-vector sessions from seed 0000, golden 0000.
        tbl[0] = '{8'h01, 8'h02, 16'h0001, 16'h0000, 1'b1};
        tbl[1] = '{8'h80, 8'h00, 16'h0080, 16'h0100, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 16'h00FF, 16'h0101, 1'b0};
        tbl[3] = '{8'h00, 8'h00, 16'h0000, 16'h0000, 1'b1};
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            prod_tab[0] = tbl[r].p0;
            prod_tab[1] = tbl[r].p1;
            applyStimulus(1, 1'b1);
            tick(1);
            tick(6);
            checkOutput($sformatf("tbl%0d sig1", r), 32'(sig[1]), 32'(tbl[r].s1));
            checkOutput($sformatf("tbl%0d vec1", r), 32'(vec[1]), 32'h1);
            tick(6);
            checkOutput($sformatf("tbl%0d done", r), 32'(done[1]), 32'h1);
            checkOutput($sformatf("tbl%0d sig2", r), 32'(sig[1]), 32'(tbl[r].s2));
            checkOutput($sformatf("tbl%0d pass", r), 32'(pass[1]), 32'(tbl[r].exp_pass));
            checkOutput($sformatf("tbl%0d timeout", r), 32'(tmo[1]), 32'h0);
            applyStimulus(1, 1'b0);
            tick(1);
        end

        // Hung multiplier: timeout after 8 WAIT cycles.
        @(negedge clk) hang[2] = 1'b1;
        applyStimulus(2, 1'b1);
        tick(1);
        tick(8);
        checkOutput("hung done early", 32'(done[2]), 32'h0);
        tick(1);
        checkOutput("hung done", 32'(done[2]), 32'h1);
        checkOutput("hung timeout", 32'(tmo[2]), 32'h1);
        checkOutput("hung pass", 32'(pass[2]), 32'h0);
        checkOutput("hung vec_count", 32'(vec[2]), 32'h0);
        @(negedge clk) rst = 1'b1;
        #1;
        checkOutput("reset clears timeout", 32'(tmo[2]), 32'h0);
        checkOutput("reset clears done", 32'(done[2]), 32'h0);
        te[2] = 1'b0;
        hang[2] = 1'b0;
        @(negedge clk) rst = 1'b0;

        // Abort during WAIT of vector 3, then reseed.
        applyStimulus(2, 1'b1);
        tick(1);
        tick(15);
        checkOutput("abort pre vec_count", 32'(vec[2]), 32'h2);
        applyStimulus(2, 1'b0);
        tick(1);
        checkOutput("abort done", 32'(done[2]), 32'h0);
        checkOutput("abort vec_count", 32'(vec[2]), 32'h2);
        checkOutput("abort sig held", 32'(sig[2]), 32'(model_sig(2)));
        tick(3);
        checkOutput("abort idle start", 32'(start[2]), 32'h0);
        applyStimulus(2, 1'b1);
        tick(1);
        checkOutput("reseed sig", 32'(sig[2]), 32'hFFFF);
        checkOutput("reseed vec_count", 32'(vec[2]), 32'h0);
        checkOutput("reseed start", 32'(start[2]), 32'h1);
        applyStimulus(2, 1'b0);
        tick(1);

        // Asynchronous reset in the middle of WAIT.
        applyStimulus(2, 1'b1);
        tick(1);
        tick(8);
        checkOutput("midwait pre vec_count", 32'(vec[2]), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midwait rst start", 32'(start[2]), 32'h0);
        checkOutput("midwait rst vec_count", 32'(vec[2]), 32'h0);
        checkOutput("midwait rst sig", 32'(sig[2]), 32'hFFFF);
        checkOutput("midwait rst done", 32'(done[2]), 32'h0);
        tick(2);
        checkOutput("held rst start", 32'(start[2]), 32'h0);
        te[2] = 1'b0;
        @(negedge clk) rst = 1'b0;

        // Full 64-vector LFSR session.
        @(negedge clk) mon_en = 1'b1;
        applyStimulus(2, 1'b1);
        tick(1);
        n = 0;
        done_seen = 1'b0;
        while (n < 500 && !done_seen) begin
            tick(1);
            n++;
            done_seen = done[2];
        end
        checkOutput("run64 done latency", 32'(n), 32'd384);
        checkOutput("run64 signature", 32'(sig[2]), 32'(GOLD64));
        checkOutput("run64 pass", 32'(pass[2]), 32'h1);
        checkOutput("run64 vec_count", 32'(vec[2]), 32'd64);
        checkOutput("run64 timeout", 32'(tmo[2]), 32'h0);
        checkOutput("run64 start count", 32'(start_cnt), 32'd64);
        checkOutput("run64 start spacing", 32'(spacing_bad), 32'd0);
        applyStimulus(2, 1'b0);
        mon_en = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
